pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
Free-running PWM pattern generator that produces the raw PWM bit (pwm_d) for the output-retiming flip-flop. That flip-flop registers pwm_d on ck to drive the pin. Period and duty are loaded through a valid/ready handshake into shadow registers, and are applied only at a period boundary so no runt or partial pulse is emitted. The block also exposes the counter and a period-end strobe for timing and debug.

Parameters:
WIDTH, 8, width of counter, period and duty.
RST_PERIOD, 255, active period value after reset (terminal count; cycle length = period+1).
RST_DUTY, 0, active duty value after reset (number of high cycles per period).

Ports:
ck  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  run enable; 0 forces IDLE.
cfg_valid  input  1  new period/duty offered.
cfg_period  input  WIDTH  terminal count for new configuration.
cfg_duty  input  WIDTH  high-cycle count for new configuration.
cfg_ready  output  1  shadow register free; config is accepted when cfg_valid & cfg_ready.
pwm_d  output  1  raw PWM bit to the output flip-flop.
cnt  output  WIDTH  current counter value.
period_end  output  1  high in the last cycle of each period while RUN.

Behaviour:
- Reset is asynchronous, active-high, and may occur mid-operation. Reset values:
  - state=IDLE, cnt=0, pwm_d=0, period_end=0, cfg_ready=1, pending=0.
  - period_act=RST_PERIOD, duty_act=RST_DUTY, shadow registers=0.
- Registers: cnt, period_act, duty_act, shadow_period, shadow_duty, pending flag, state.
- Outputs derived from registers:
  - pwm_d = (state==RUN) & (cnt < duty_act). This is a pure decode of registers; the retiming flip-flop removes decode glitches.
  - period_end = (state==RUN) & (cnt==period_act).
  - cfg_ready = ~pending.
- IDLE state:
  - cnt held at 0; pwm_d=0.
  - If pending=1, apply the shadow registers (period_act, duty_act <= shadow) on the next edge and clear pending.
  - Transition: en=1 -> RUN on the next edge, with cnt=0 in the first RUN cycle.
- RUN state:
  - Each edge: if cnt==period_act, cnt <= 0 (wrap); else cnt <= cnt+1. Arithmetic is unsigned WIDTH-bit; no overflow is possible because cnt never exceeds period_act.
  - Wrap edge: if pending was 1 at that edge, apply the shadow registers and clear pending. The new values govern the period that starts with cnt=0.
  - en=0 -> IDLE on the next edge: cnt=0, pwm_d=0. A truncated period is allowed here. A pending config is applied in IDLE as described above.
- Handshake:
  - Acceptance occurs on an edge where cfg_valid & cfg_ready: shadow registers <= cfg inputs, pending <= 1, so cfg_ready=0 from the next cycle.
  - cfg_valid while cfg_ready=0 is ignored; the upstream holds its request.
  - Acceptance on the same edge as a wrap is not applied at that wrap. It is applied at the following wrap, because only pending that was already set counts.
  - cfg_ready returns to 1 the cycle after application.
- Duty boundaries:
  - duty_act=0: pwm_d constantly 0.
  - duty_act > period_act: pwm_d constantly 1 (100%).
  - duty_act = period_act: high for period_act cycles, low for 1 cycle.
- Period boundary: period_act=0 gives cnt always 0 and period_end=1 every RUN cycle. In that case pwm_d=1 iff duty_act>=1.
- Latency: pwm_d changes in the same cycle as cnt, with no added pipeline. Pin latency is +1 through the downstream flip-flop.

Test Plan:
1. Reset asserted mid-RUN with cnt=5 -> cnt=0, pwm_d=0, cfg_ready=1 immediately (asynchronous, no clock edge needed). After release with en=1 and default config (255/0), pwm_d stays 0.
2. Load period=9, duty=3 in IDLE, then en=1 -> a repeating 10-cycle pattern: pwm_d=1 for cnt 0..2, 0 for cnt 3..9, and period_end=1 only at cnt=9.
3. While running 9/3, at cnt=4 offer period=4, duty=2 -> cfg_ready drops the next cycle. The current period completes with the 9/3 pattern, then a 5-cycle pattern starts (high 2, low 3). cfg_ready returns to 1 one cycle after the wrap.
4. Config accepted exactly at cnt=period_act -> the old pattern runs one more full period, and the new one starts at the following wrap.
5. Duty boundaries with period=9: duty=0 -> pwm_d is never 1; duty=10 and duty=255 -> pwm_d is always 1; duty=9 -> 9 cycles high, 1 low. Separately, period=0 with duty=1 -> pwm_d=1 and period_end=1 every cycle.
6. Drop en at cnt=6 -> IDLE on the next edge with cnt=0 and pwm_d=0. A pending config offered during RUN is applied in IDLE, and cfg_ready=1 within 2 cycles. Re-asserting en restarts at cnt=0.

Source files
------------

// File: rtl/pwm_gen.sv
// -----------------------------------------------------------------------------
// pwm_gen
//
// Free-running PWM pattern generator. Produces the raw PWM bit (pwm_d) that a
// downstream retiming flip-flop registers on ck to drive the pin. Period and
// duty are loaded through a valid/ready handshake into shadow registers and
// only become active at a period boundary (or while idle), so a running
// pattern never emits a runt or partial pulse because of a reconfiguration.
//
// Parameters:
//   WIDTH       width of the counter, period and duty
//   RST_PERIOD  active period (terminal count) after reset; period length is
//               period+1 cycles
//   RST_DUTY    active duty after reset (high cycles per period)
//
// Ports:
//   ck          in   system clock, all state on the rising edge
//   reset       in   asynchronous, active-high reset
//   en          in   run enable; 0 returns the generator to IDLE
//   cfg_valid   in   a new period/duty pair is offered
//   cfg_period  in   terminal count of the offered configuration
//   cfg_duty    in   high-cycle count of the offered configuration
//   cfg_ready   out  shadow register is free
//   pwm_d       out  raw PWM bit (decode of registers, retimed downstream)
//   cnt         out  current counter value
//   period_end  out  high in the last cycle of each period while running
// -----------------------------------------------------------------------------
module pwm_gen #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned RST_PERIOD = 255,
  parameter int unsigned RST_DUTY   = 0
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             cfg_ready,
  output logic             pwm_d,
  output logic [WIDTH-1:0] cnt,
  output logic             period_end
);

  // Configuration handshake (valid/ready):
  //   A configuration is transferred on every rising edge where
  //   cfg_valid & cfg_ready are both high. cfg_ready depends only on the
  //   registered pending flag, never on cfg_valid, so there is no
  //   combinational path from valid to ready. An upstream that sees
  //   cfg_ready low keeps cfg_valid and its data stable until a transfer
  //   edge; offers made while cfg_ready is low are simply not taken.
  //   After a transfer cfg_ready stays low until the shadow values have been
  //   made active, and rises in the cycle after that.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] RST_PERIOD_W = WIDTH'(RST_PERIOD);
  localparam logic [WIDTH-1:0] RST_DUTY_W   = WIDTH'(RST_DUTY);
  localparam logic [WIDTH-1:0] ONE_W        = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] shadow_period_q, shadow_period_d;
  logic [WIDTH-1:0] shadow_duty_q, shadow_duty_d;
  logic             pending_q, pending_d;

  // ---------------------------------------------------------------------------
  // Shared decodes
  // ---------------------------------------------------------------------------
  logic is_run;
  logic at_terminal;
  logic wrap;
  logic accept;
  logic apply;

  always_comb begin
    is_run      = (state_q == ST_RUN);
    at_terminal = (cnt_q == period_act_q);
    // A wrap edge is the edge that ends the current period while running.
    wrap        = is_run & at_terminal;
    accept      = cfg_valid & ~pending_q;
    // Only a pending flag that was already set before this edge is applied,
    // so a config accepted on a wrap edge waits for the following wrap.
    apply       = pending_q & (~is_run | wrap);
  end

  // ---------------------------------------------------------------------------
  // FSM process 1: state register (plus datapath registers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      period_act_q    <= RST_PERIOD_W;
      duty_act_q      <= RST_DUTY_W;
      shadow_period_q <= '0;
      shadow_duty_q   <= '0;
      pending_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      period_act_q    <= period_act_d;
      duty_act_q      <= duty_act_d;
      shadow_period_q <= shadow_period_d;
      shadow_duty_q   <= shadow_duty_d;
      pending_q       <= pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)  state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state: counter, active config, shadow config, pending flag
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d           = cnt_q;
    period_act_d    = period_act_q;
    duty_act_d      = duty_act_q;
    shadow_period_d = shadow_period_q;
    shadow_duty_d   = shadow_duty_q;
    pending_d       = pending_q;

    // Counter: held at 0 in IDLE and on the edge that leaves RUN, so the
    // first RUN cycle always starts a fresh period at cnt=0.
    if (is_run && en) begin
      if (at_terminal) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE_W;
      end
    end else begin
      cnt_d = '0;
    end

    // accept and apply are mutually exclusive: accept needs pending low,
    // apply needs pending high.
    if (apply) begin
      period_act_d = shadow_period_q;
      duty_act_d   = shadow_duty_q;
      pending_d    = 1'b0;
    end

    if (accept) begin
      shadow_period_d = cfg_period;
      shadow_duty_d   = cfg_duty;
      pending_d       = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs (pure decode of registers)
  // ---------------------------------------------------------------------------
  always_comb begin
    // duty > period gives 100% high, duty = 0 gives constant low; both fall
    // out of the plain unsigned compare.
    pwm_d      = is_run & (cnt_q < duty_act_q);
    period_end = is_run & at_terminal;
    cfg_ready  = ~pending_q;
    cnt        = cnt_q;
  end

endmodule

// File: tb/tb_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_pwm_gen
//
// Self-checking bench for pwm_gen (WIDTH=8, RST_PERIOD=255, RST_DUTY=0).
// The reference model thinks in whole periods: whenever a new period starts
// it lays out the full list of {cnt, pwm, period_end} values for that period
// from the active period/duty, and each running cycle consumes one entry.
// A config becomes active only when a period list is exhausted or while idle.
// -----------------------------------------------------------------------------
module tb_pwm_gen;

  localparam int W  = 8;
  localparam int EW = W + 2;   // {cnt, pwm, period_end}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic         ck;
  logic         reset;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_duty;
  logic         cfg_ready;
  logic         pwm_d;
  logic [W-1:0] cnt;
  logic         period_end;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  pwm_gen #(
    .WIDTH      (W),
    .RST_PERIOD (255),
    .RST_DUTY   (0)
  ) dut (
    .ck         (ck),
    .reset      (reset),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_ready  (cfg_ready),
    .pwm_d      (pwm_d),
    .cnt        (cnt),
    .period_end (period_end)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  int            vectors;
  int            miscompares;
  string         cur_tag;

  bit            m_run;
  bit            m_pend;
  logic [W-1:0]  m_per, m_duty, m_sp, m_sd;
  logic [EW-1:0] exp_q[$];

  function automatic void model_reset();
    m_run  = 1'b0;
    m_pend = 1'b0;
    m_per  = 8'd255;
    m_duty = 8'd0;
    m_sp   = '0;
    m_sd   = '0;
    exp_q.delete();
  endfunction

  // Lay out one complete period from the active configuration.
  function automatic void fill_period();
    for (int i = 0; i <= int'(m_per); i++) begin
      exp_q.push_back({8'(i), (i < int'(m_duty)), (i == int'(m_per))});
    end
  endfunction

  function automatic void apply_shadow();
    m_per  = m_sp;
    m_duty = m_sd;
    m_pend = 1'b0;
  endfunction

  // Expected {cnt, pwm_d, period_end, cfg_ready} in the current cycle.
  function automatic logic [EW:0] expected();
    if (!m_run || exp_q.size() == 0) return {8'h00, 1'b0, 1'b0, !m_pend};
    return {exp_q[0], !m_pend};
  endfunction

  // Advance the model across one rising edge with the given inputs.
  function automatic void model_edge(input bit e, input bit acc,
                                     input logic [W-1:0] p, input logic [W-1:0] d);
    if (m_run) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0 && m_pend) apply_shadow();
      if (!e) begin
        m_run = 1'b0;
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        fill_period();
      end
    end else begin
      if (m_pend) apply_shadow();
      if (e) begin
        m_run = 1'b1;
        fill_period();
      end
    end
    if (acc) begin
      m_pend = 1'b1;
      m_sp   = p;
      m_sd   = d;
    end
  endfunction

  function automatic int model_cnt();
    if (!m_run || exp_q.size() == 0) return 0;
    return int'(exp_q[0][EW-1:2]);
  endfunction

  task automatic check(input string tag, input logic [EW:0] obs, input logic [EW:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed cnt/pwm/end/rdy=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1, away from the active edge)
  // ---------------------------------------------------------------------------
  task automatic step(input bit e, input bit v, input logic [W-1:0] p, input logic [W-1:0] d);
    bit acc;
    check(cur_tag, {cnt, pwm_d, period_end, cfg_ready}, expected());
    en         = e;
    cfg_valid  = v;
    cfg_period = p;
    cfg_duty   = d;
    acc        = v && !m_pend;
    @(posedge ck);
    #1;
    model_edge(e, acc, p, d);
  endtask

  task automatic run(input bit e, input int n);
    for (int i = 0; i < n; i++) step(e, 1'b0, '0, '0);
  endtask

  // Offer a config and hold it until it is taken (bounded).
  task automatic load(input bit e, input logic [W-1:0] p, input logic [W-1:0] d);
    bit taken;
    taken = 1'b0;
    for (int i = 0; i < 600 && !taken; i++) begin
      taken = !m_pend;
      step(e, 1'b1, p, d);
    end
    vectors++;
    assert (taken) else begin
      miscompares++;
      $error("FAIL %s_load observed taken=%0d expected=1", cur_tag, taken);
    end
  endtask

  // Run with en=1 until the model says the counter equals c (bounded).
  task automatic run_until_cnt(input int c);
    bit found;
    found = (m_run && model_cnt() == c);
    for (int i = 0; i < 600 && !found; i++) begin
      step(1'b1, 1'b0, '0, '0);
      found = (m_run && model_cnt() == c);
    end
    vectors++;
    assert (found) else begin
      miscompares++;
      $error("FAIL %s_wait observed cnt=%0d expected=%0d", cur_tag, cnt, c);
    end
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    check({cur_tag, "_async"}, {cnt, pwm_d, period_end, cfg_ready}, {8'h00, 1'b0, 1'b0, 1'b1});
    model_reset();
    @(posedge ck);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    en          = 1'b0;
    cfg_valid   = 1'b0;
    cfg_period  = '0;
    cfg_duty    = '0;
    model_reset();
    repeat (2) @(posedge ck);
    #1;
    reset = 1'b0;

    // Reset state, then default 255/0 pattern and a mid-run reset at cnt=5.
    cur_tag = "reset_state";
    run(1'b0, 3);
    cur_tag = "default_run";
    run(1'b1, 8);
    run_until_cnt(5);
    async_reset();
    cur_tag = "after_reset";
    run(1'b1, 20);

    // 9/3 loaded in IDLE.
    cur_tag = "idle_load";
    run(1'b0, 2);
    load(1'b0, 8'd9, 8'd3);
    run(1'b0, 2);
    cur_tag = "p9_d3";
    run(1'b1, 25);

    // Reconfigure mid-period at cnt=4 to 4/2.
    cur_tag = "mid_cfg";
    run_until_cnt(4);
    step(1'b1, 1'b1, 8'd4, 8'd2);
    run(1'b1, 22);

    // Config accepted exactly on the wrap cycle.
    cur_tag = "wrap_cfg";
    run_until_cnt(4);
    step(1'b1, 1'b1, 8'd9, 8'd3);
    run(1'b1, 25);

    // Duty boundaries with period 9.
    cur_tag = "duty_0";
    load(1'b1, 8'd9, 8'd0);
    run(1'b1, 25);
    cur_tag = "duty_10";
    load(1'b1, 8'd9, 8'd10);
    run(1'b1, 25);
    cur_tag = "duty_255";
    load(1'b1, 8'd9, 8'd255);
    run(1'b1, 25);
    cur_tag = "duty_9";
    load(1'b1, 8'd9, 8'd9);
    run(1'b1, 25);
    cur_tag = "period_0";
    load(1'b1, 8'd0, 8'd1);
    run(1'b1, 10);

    // Drop en at cnt=6 with a config pending from RUN.
    cur_tag = "en_drop";
    load(1'b1, 8'd9, 8'd3);
    run(1'b1, 12);
    run_until_cnt(2);
    step(1'b1, 1'b1, 8'd5, 8'd2);
    run_until_cnt(6);
    run(1'b0, 4);
    run(1'b1, 15);

    // Randomized traffic with occasional enable drops and resets.
    cur_tag = "random";
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0),
             8'($urandom_range(0, 15)), 8'($urandom_range(0, 17)));
      end
    end
    run(1'b1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
